// File: rtl/pipe_hazard_unit_pkg.sv
// Shared definitions for the pipeline hazard unit: forward-select codes,
// FSM state encoding and stage index positions in the stage_en/stage_rst vectors.
package pipe_hazard_unit_pkg;

  localparam logic [2:0] FWD_RF       = 3'd0;
  localparam logic [2:0] FWD_EXE_ALU  = 3'd1;
  localparam logic [2:0] FWD_MEM_ALU  = 3'd2;
  localparam logic [2:0] FWD_MEM_LOAD = 3'd3;
  localparam logic [2:0] FWD_WB       = 3'd4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LSTALL = 2'd1,
    ST_MWAIT  = 2'd2,
    ST_DHOLD  = 2'd3
  } state_t;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EXE = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// Pipeline <-> hazard unit bundle. The pipeline side is the master; the
// hazard unit is the slave that returns stage controls and forward selects.
interface pipe_hazard_unit_if #(
  parameter int RA_W = 5
);
  logic [RA_W-1:0] id_rs;
  logic [RA_W-1:0] id_rt;
  logic            id_rs_used;
  logic            id_rt_used;
  logic            id_is_store;
  logic            id_mdu_read;
  logic            id_branch_taken;
  logic [RA_W-1:0] exe_dst;
  logic            exe_wen;
  logic            exe_is_load;
  logic [RA_W-1:0] mem_dst;
  logic            mem_wen;
  logic            mem_is_load;
  logic            mem_is_store;
  logic [RA_W-1:0] mem_rt;
  logic [RA_W-1:0] wb_dst;
  logic            wb_wen;
  logic            mdu_busy;
  logic            debug_en;
  logic            debug_step;

  logic [4:0]      stage_en;
  logic [4:0]      stage_rst;
  logic [2:0]      fwd_a;
  logic [2:0]      fwd_b;
  logic            fwd_mem;
  logic [1:0]      stall_state;

  modport master (
    output id_rs, id_rt, id_rs_used, id_rt_used, id_is_store, id_mdu_read,
           id_branch_taken, exe_dst, exe_wen, exe_is_load, mem_dst, mem_wen,
           mem_is_load, mem_is_store, mem_rt, wb_dst, wb_wen, mdu_busy,
           debug_en, debug_step,
    input  stage_en, stage_rst, fwd_a, fwd_b, fwd_mem, stall_state
  );

  modport slave (
    input  id_rs, id_rt, id_rs_used, id_rt_used, id_is_store, id_mdu_read,
           id_branch_taken, exe_dst, exe_wen, exe_is_load, mem_dst, mem_wen,
           mem_is_load, mem_is_store, mem_rt, wb_dst, wb_wen, mdu_busy,
           debug_en, debug_step,
    output stage_en, stage_rst, fwd_a, fwd_b, fwd_mem, stall_state
  );
endinterface

// File: rtl/pipe_hazard_unit_fwd_sel.sv
// Per-operand forward selection: finds the youngest writing stage that matches
// the source address and flags the load cases that must stall instead.
module hazard_fwd_sel
  import pipe_hazard_unit_pkg::*;
#(
  parameter int RA_W     = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic [RA_W-1:0] src,
  input  logic            used,
  input  logic [RA_W-1:0] exe_dst,
  input  logic            exe_wen,
  input  logic            exe_is_load,
  input  logic [RA_W-1:0] mem_dst,
  input  logic            mem_wen,
  input  logic            mem_is_load,
  input  logic [RA_W-1:0] wb_dst,
  input  logic            wb_wen,
  output logic [2:0]      fwd,
  output logic            exe_stall,
  output logic            mem_stall
);

  // NOTE: every output gets a default before the if-chain so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    fwd       = FWD_RF;
    exe_stall = 1'b0;
    mem_stall = 1'b0;
    if (used && (src != '0)) begin
      if (exe_wen && (exe_dst == src)) begin
        if (exe_is_load) exe_stall = 1'b1;
        else             fwd       = FWD_EXE_ALU;
      end else if (mem_wen && (mem_dst == src)) begin
        if (!mem_is_load)       fwd       = FWD_MEM_ALU;
        else if (LOAD_LAT == 1) fwd       = FWD_MEM_LOAD;
        else                    mem_stall = 1'b1;
      end else if (wb_wen && (wb_dst == src)) begin
        fwd = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use and HI/LO stalls,
// branch squash and optional single-step debug hold.
module pipe_hazard_unit
  import pipe_hazard_unit_pkg::*;
#(
  parameter int RA_W       = 5,
  parameter int LOAD_LAT   = 1,
  parameter int DELAY_SLOT = 1,
  parameter int DEBUG      = 0
) (
  input logic              clk,
  input logic              rst,
  pipe_hazard_unit_if.slave hz
);

  localparam logic [1:0] LAT_M1 = 2'(LOAD_LAT - 1);

  state_t     state, state_n;
  logic [1:0] cnt, cnt_n;
  logic       step_q;

  logic [2:0] fwd_a_raw, fwd_b_raw;
  logic       a_exe_stall, a_mem_stall, b_exe_stall, b_mem_stall;
  logic       exe_stall, load_stall, mdu_stall, hold, step_rise;
  logic       bubble, squash;
  logic [4:0] en_n;

  hazard_fwd_sel #(.RA_W(RA_W), .LOAD_LAT(LOAD_LAT)) u_sel_a (
    .src(hz.id_rs), .used(hz.id_rs_used),
    .exe_dst(hz.exe_dst), .exe_wen(hz.exe_wen), .exe_is_load(hz.exe_is_load),
    .mem_dst(hz.mem_dst), .mem_wen(hz.mem_wen), .mem_is_load(hz.mem_is_load),
    .wb_dst(hz.wb_dst), .wb_wen(hz.wb_wen),
    .fwd(fwd_a_raw), .exe_stall(a_exe_stall), .mem_stall(a_mem_stall)
  );

  // A store's rt is its data operand; it is resolved in MEM via fwd_mem instead.
  hazard_fwd_sel #(.RA_W(RA_W), .LOAD_LAT(LOAD_LAT)) u_sel_b (
    .src(hz.id_rt), .used(hz.id_rt_used && !hz.id_is_store),
    .exe_dst(hz.exe_dst), .exe_wen(hz.exe_wen), .exe_is_load(hz.exe_is_load),
    .mem_dst(hz.mem_dst), .mem_wen(hz.mem_wen), .mem_is_load(hz.mem_is_load),
    .wb_dst(hz.wb_dst), .wb_wen(hz.wb_wen),
    .fwd(fwd_b_raw), .exe_stall(b_exe_stall), .mem_stall(b_mem_stall)
  );

  assign exe_stall  = a_exe_stall || b_exe_stall;
  assign load_stall = exe_stall || a_mem_stall || b_mem_stall;
  assign mdu_stall  = hz.id_mdu_read && hz.mdu_busy;
  assign hold       = (DEBUG != 0) && hz.debug_en;
  assign step_rise  = hz.debug_step && !step_q;

  // Released wait states fall through to the RUN evaluation so that a
  // pending load-use or HI/LO hazard is picked up in the same cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bubble  = 1'b0;
    squash  = 1'b0;
    en_n    = '1;
    if (hold) begin
      state_n = ST_DHOLD;
      cnt_n   = '0;
      en_n    = step_rise ? 5'b11111 : 5'b00000;
    end else if ((state == ST_LSTALL) && (cnt != '0)) begin
      bubble = 1'b1;
      cnt_n  = cnt - 2'd1;
    end else if ((state == ST_MWAIT) && hz.mdu_busy) begin
      bubble = 1'b1;
    end else if (load_stall) begin
      bubble  = 1'b1;
      state_n = ST_LSTALL;
      cnt_n   = exe_stall ? LAT_M1 : 2'd0;
    end else if (mdu_stall) begin
      bubble  = 1'b1;
      state_n = ST_MWAIT;
    end else begin
      state_n = ST_RUN;
      cnt_n   = '0;
      squash  = (DELAY_SLOT == 0) && hz.id_branch_taken &&
                ((state == ST_RUN) || (state == ST_DHOLD));
    end
  end

  always_comb begin
    hz.stage_en  = en_n;
    hz.stage_rst = '0;
    if (bubble) begin
      hz.stage_en[STG_IF]   = 1'b0;
      hz.stage_en[STG_ID]   = 1'b0;
      hz.stage_rst[STG_EXE] = 1'b1;
    end
    if (squash) hz.stage_rst[STG_ID] = 1'b1;
    if (rst) begin
      hz.stage_en  = '1;
      hz.stage_rst = '1;
    end
  end

  assign hz.fwd_a       = rst ? FWD_RF : fwd_a_raw;
  assign hz.fwd_b       = rst ? FWD_RF : fwd_b_raw;
  assign hz.fwd_mem     = !rst && hz.mem_is_store && (hz.mem_rt != '0) &&
                          hz.wb_wen && (hz.wb_dst == hz.mem_rt);
  assign hz.stall_state = state;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_RUN;
      cnt    <= '0;
      step_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      step_q <= hz.debug_step;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench: u_a (LOAD_LAT=1, squash, debug) and u_b (LOAD_LAT=2, delay
// slot, no debug) see identical stimulus; expected values are hand-derived.
module tb_pipe_hazard_unit;
  import pipe_hazard_unit_pkg::*;

  localparam logic [4:0] EN_ALL  = 5'b11111;
  localparam logic [4:0] EN_BUB  = 5'b11100;
  localparam logic [4:0] EN_NONE = 5'b00000;
  localparam logic [4:0] R_NONE  = 5'b00000;
  localparam logic [4:0] R_BUB   = 5'b00100;
  localparam logic [4:0] R_SQ    = 5'b00010;
  localparam logic [4:0] R_ALL   = 5'b11111;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pipe_hazard_unit_if #(.RA_W(5)) ha ();
  pipe_hazard_unit_if #(.RA_W(5)) hb ();

  assign hb.id_rs           = ha.id_rs;
  assign hb.id_rt           = ha.id_rt;
  assign hb.id_rs_used      = ha.id_rs_used;
  assign hb.id_rt_used      = ha.id_rt_used;
  assign hb.id_is_store     = ha.id_is_store;
  assign hb.id_mdu_read     = ha.id_mdu_read;
  assign hb.id_branch_taken = ha.id_branch_taken;
  assign hb.exe_dst         = ha.exe_dst;
  assign hb.exe_wen         = ha.exe_wen;
  assign hb.exe_is_load     = ha.exe_is_load;
  assign hb.mem_dst         = ha.mem_dst;
  assign hb.mem_wen         = ha.mem_wen;
  assign hb.mem_is_load     = ha.mem_is_load;
  assign hb.mem_is_store    = ha.mem_is_store;
  assign hb.mem_rt          = ha.mem_rt;
  assign hb.wb_dst          = ha.wb_dst;
  assign hb.wb_wen          = ha.wb_wen;
  assign hb.mdu_busy        = ha.mdu_busy;
  assign hb.debug_en        = ha.debug_en;
  assign hb.debug_step      = ha.debug_step;

  pipe_hazard_unit #(.RA_W(5), .LOAD_LAT(1), .DELAY_SLOT(0), .DEBUG(1)) u_a (
    .clk(clk), .rst(rst), .hz(ha)
  );
  pipe_hazard_unit #(.RA_W(5), .LOAD_LAT(2), .DELAY_SLOT(1), .DEBUG(0)) u_b (
    .clk(clk), .rst(rst), .hz(hb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    ha.id_rs = '0; ha.id_rt = '0; ha.id_rs_used = 1'b0; ha.id_rt_used = 1'b0;
    ha.id_is_store = 1'b0; ha.id_mdu_read = 1'b0; ha.id_branch_taken = 1'b0;
    ha.exe_dst = '0; ha.exe_wen = 1'b0; ha.exe_is_load = 1'b0;
    ha.mem_dst = '0; ha.mem_wen = 1'b0; ha.mem_is_load = 1'b0;
    ha.mem_is_store = 1'b0; ha.mem_rt = '0;
    ha.wb_dst = '0; ha.wb_wen = 1'b0; ha.mdu_busy = 1'b0;
    ha.debug_en = 1'b0; ha.debug_step = 1'b0;
  endtask

  task automatic load_in_exe();
    ha.exe_dst = 5'd5; ha.exe_wen = 1'b1; ha.exe_is_load = 1'b1;
    ha.id_rs = 5'd5; ha.id_rs_used = 1'b1;
  endtask

  initial begin
    int bubbles;
    int steps;
    logic [7:0] step_seq;

    // Reset forces all controls even with a load-use hazard present.
    rst = 1'b1;
    clear_in();
    @(negedge clk);
    load_in_exe();
    #1;
    check("rst stage_rst", 32'(ha.stage_rst), 32'(R_ALL));
    check("rst stage_en", 32'(ha.stage_en), 32'(EN_ALL));
    check("rst fwd_a", 32'(ha.fwd_a), 32'(FWD_RF));
    check("rst state", 32'(ha.stall_state), 32'(ST_RUN));

    // Load-use: first bubble in the detection cycle; branch ignored in bubbles.
    @(negedge clk);
    rst = 1'b0;
    ha.id_branch_taken = 1'b1;
    #1;
    check("lu a en c1", 32'(ha.stage_en), 32'(EN_BUB));
    check("lu a rst c1", 32'(ha.stage_rst), 32'(R_BUB));
    check("lu b en c1", 32'(hb.stage_en), 32'(EN_BUB));
    check("lu a state c1", 32'(ha.stall_state), 32'(ST_RUN));

    @(negedge clk);
    clear_in();
    ha.mem_dst = 5'd5; ha.mem_wen = 1'b1; ha.mem_is_load = 1'b1;
    ha.id_rs = 5'd5; ha.id_rs_used = 1'b1; ha.id_branch_taken = 1'b1;
    #1;
    check("lu a en c2", 32'(ha.stage_en), 32'(EN_ALL));
    check("lu a no squash LSTALL", 32'(ha.stage_rst), 32'(R_NONE));
    check("lu a fwd_a c2", 32'(ha.fwd_a), 32'(FWD_MEM_LOAD));
    check("lu a state c2", 32'(ha.stall_state), 32'(ST_LSTALL));
    check("lu b en c2", 32'(hb.stage_en), 32'(EN_BUB));
    check("lu b state c2", 32'(hb.stall_state), 32'(ST_LSTALL));

    @(negedge clk);
    clear_in();
    ha.wb_dst = 5'd5; ha.wb_wen = 1'b1; ha.id_rs = 5'd5; ha.id_rs_used = 1'b1;
    #1;
    check("lu a fwd_a c3", 32'(ha.fwd_a), 32'(FWD_WB));
    check("lu a state c3", 32'(ha.stall_state), 32'(ST_RUN));
    check("lu b en c3", 32'(hb.stage_en), 32'(EN_ALL));
    check("lu b fwd_a c3", 32'(hb.fwd_a), 32'(FWD_WB));

    // Forward priority on operand B.
    @(negedge clk);
    clear_in();
    ha.exe_dst = 5'd7; ha.mem_dst = 5'd7; ha.wb_dst = 5'd7;
    ha.exe_wen = 1'b1; ha.mem_wen = 1'b1; ha.wb_wen = 1'b1;
    ha.id_rt = 5'd7; ha.id_rt_used = 1'b1;
    #1;
    check("fwd_b exe", 32'(ha.fwd_b), 32'(FWD_EXE_ALU));
    check("fwd_a unused", 32'(ha.fwd_a), 32'(FWD_RF));
    check("b state run", 32'(hb.stall_state), 32'(ST_RUN));
    @(negedge clk);
    ha.id_rt = 5'd0;
    #1;
    check("fwd_b r0", 32'(ha.fwd_b), 32'(FWD_RF));
    @(negedge clk);
    ha.id_rt = 5'd7; ha.exe_wen = 1'b0;
    #1;
    check("fwd_b mem alu", 32'(ha.fwd_b), 32'(FWD_MEM_ALU));
    @(negedge clk);
    ha.mem_wen = 1'b0;
    #1;
    check("fwd_b wb", 32'(ha.fwd_b), 32'(FWD_WB));
    @(negedge clk);
    ha.id_is_store = 1'b1;
    #1;
    check("fwd_b store", 32'(ha.fwd_b), 32'(FWD_RF));

    // MEM load match: code 3 at LOAD_LAT=1, one-bubble stall at LOAD_LAT=2.
    @(negedge clk);
    clear_in();
    ha.mem_dst = 5'd9; ha.mem_wen = 1'b1; ha.mem_is_load = 1'b1;
    ha.id_rs = 5'd9; ha.id_rs_used = 1'b1;
    #1;
    check("memld a fwd_a", 32'(ha.fwd_a), 32'(FWD_MEM_LOAD));
    check("memld a en", 32'(ha.stage_en), 32'(EN_ALL));
    check("memld b en", 32'(hb.stage_en), 32'(EN_BUB));
    @(negedge clk);
    clear_in();
    #1;
    check("memld b en next", 32'(hb.stage_en), 32'(EN_ALL));
    check("memld b state next", 32'(hb.stall_state), 32'(ST_LSTALL));

    // Store-data forward from WB.
    @(negedge clk);
    clear_in();
    ha.mem_is_store = 1'b1; ha.mem_rt = 5'd6; ha.wb_wen = 1'b1; ha.wb_dst = 5'd6;
    #1;
    check("fwd_mem hit", 32'(ha.fwd_mem), 32'd1);
    @(negedge clk);
    ha.wb_dst = 5'd7;
    #1;
    check("fwd_mem miss", 32'(ha.fwd_mem), 32'd0);

    // Branch squash in RUN.
    @(negedge clk);
    clear_in();
    ha.id_branch_taken = 1'b1;
    #1;
    check("squash a", 32'(ha.stage_rst), 32'(R_SQ));
    check("squash a en", 32'(ha.stage_en), 32'(EN_ALL));
    check("no squash b", 32'(hb.stage_rst), 32'(R_NONE));
    @(negedge clk);
    clear_in();
    #1;
    check("squash a one cycle", 32'(ha.stage_rst), 32'(R_NONE));

    // HI/LO read while MDU busy for 4 cycles.
    bubbles = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ha.id_mdu_read = 1'b1; ha.mdu_busy = 1'b1;
      #1;
      if (ha.stage_en == EN_BUB) bubbles++;
      check($sformatf("mwait state %0d", i), 32'(ha.stall_state),
            (i == 0) ? 32'(ST_RUN) : 32'(ST_MWAIT));
    end
    @(negedge clk);
    ha.mdu_busy = 1'b0;
    #1;
    check("mwait bubbles", 32'(bubbles), 32'd4);
    check("mwait release en", 32'(ha.stage_en), 32'(EN_ALL));
    check("mwait release state", 32'(ha.stall_state), 32'(ST_MWAIT));
    @(negedge clk);
    clear_in();
    #1;
    check("mwait back run", 32'(ha.stall_state), 32'(ST_RUN));

    // Reset in the second MWAIT cycle aborts the stall.
    @(negedge clk);
    ha.id_mdu_read = 1'b1; ha.mdu_busy = 1'b1;
    #1;
    check("mwait rst c1 en", 32'(ha.stage_en), 32'(EN_BUB));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mwait rst c2 rst", 32'(ha.stage_rst), 32'(R_ALL));
    check("mwait rst c2 en", 32'(ha.stage_en), 32'(EN_ALL));
    @(negedge clk);
    rst = 1'b0;
    clear_in();
    #1;
    check("mwait rst state", 32'(ha.stall_state), 32'(ST_RUN));
    check("mwait rst en", 32'(ha.stage_en), 32'(EN_ALL));
    check("mwait rst stage_rst", 32'(ha.stage_rst), 32'(R_NONE));

    // Debug hold with two step rises (cycles 1 and 4).
    step_seq = 8'b0001_0110;
    steps = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ha.debug_en = 1'b1;
      ha.debug_step = step_seq[i];
      #1;
      if (ha.stage_en == EN_ALL) steps++;
      check($sformatf("dbg a en %0d", i), 32'(ha.stage_en),
            (i == 1 || i == 4) ? 32'(EN_ALL) : 32'(EN_NONE));
      check($sformatf("dbg b en %0d", i), 32'(hb.stage_en), 32'(EN_ALL));
    end
    check("dbg steps", 32'(steps), 32'd2);
    check("dbg a state", 32'(ha.stall_state), 32'(ST_DHOLD));
    check("dbg b state", 32'(hb.stall_state), 32'(ST_RUN));

    // Release with a pending load-use hazard re-evaluates at once.
    @(negedge clk);
    clear_in();
    load_in_exe();
    #1;
    check("dbg rel a en", 32'(ha.stage_en), 32'(EN_BUB));
    check("dbg rel a state", 32'(ha.stall_state), 32'(ST_DHOLD));
    @(negedge clk);
    clear_in();
    #1;
    check("dbg rel a lstall", 32'(ha.stall_state), 32'(ST_LSTALL));
    check("dbg rel a en2", 32'(ha.stage_en), 32'(EN_ALL));
    check("b second bubble", 32'(hb.stage_en), 32'(EN_BUB));
    @(negedge clk);
    #1;
    check("b lstall pass", 32'(hb.stage_en), 32'(EN_ALL));

    // Reset mid-LSTALL (u_b, counter still nonzero).
    @(negedge clk);
    load_in_exe();
    #1;
    check("lrst b c1 en", 32'(hb.stage_en), 32'(EN_BUB));
    @(negedge clk);
    rst = 1'b1;
    clear_in();
    #1;
    check("lrst b c2 rst", 32'(hb.stage_rst), 32'(R_ALL));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("lrst b state", 32'(hb.stall_state), 32'(ST_RUN));
    check("lrst b en", 32'(hb.stage_en), 32'(EN_ALL));
    check("lrst b stage_rst", 32'(hb.stage_rst), 32'(R_NONE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- RA_W, 5, register-address width.
- LOAD_LAT, 1, load-use latency in cycles; legal values are 1 and 2.
- DELAY_SLOT, 1, branch delay slot: 1 means no squash, 0 means squash the fall-through instruction.
- DEBUG, 0, single-step logic: 1 means present.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- id_rs, in, RA_W, ID source address A.
- id_rt, in, RA_W, ID source address B.
- id_rs_used, in, 1, ID uses source A.
- id_rt_used, in, 1, ID uses source B.
- id_is_store, in, 1, ID instruction is a store.
- id_mdu_read, in, 1, ID instruction reads HI/LO.
- id_branch_taken, in, 1, ID resolved a taken branch or jump.
- exe_dst, in, RA_W, EXE destination address.
- exe_wen, in, 1, EXE register write enable.
- exe_is_load, in, 1, EXE instruction is a load.
- mem_dst, in, RA_W, MEM destination address.
- mem_wen, in, 1, MEM register write enable.
- mem_is_load, in, 1, MEM instruction is a load.
- mem_is_store, in, 1, MEM instruction is a store.
- mem_rt, in, RA_W, MEM store-data address.
- wb_dst, in, RA_W, WB destination address.
- wb_wen, in, 1, WB register write enable.
- mdu_busy, in, 1, multiply/divide unit busy.
- debug_en, in, 1, debug hold enable.
- debug_step, in, 1, debug step request.
- stage_en, out, 5, stage enables {wb,mem,exe,id,if}.
- stage_rst, out, 5, stage resets {wb,mem,exe,id,if}.
- fwd_a, out, 3, operand A forward select.
- fwd_b, out, 3, operand B forward select.
- fwd_mem, out, 1, store-data forward from WB.
- stall_state, out, 2, current FSM state.

Function
REQ-003 fwd_a and fwd_b encodings SHALL be: 0 = register file, 1 = EXE ALU, 2 = MEM ALU, 3 = MEM load data, 4 = WB data.
REQ-004 For each used source with nonzero address, fwd SHALL select the youngest matching stage with wen set, checked in the order EXE, MEM, WB.
REQ-005 A MEM match SHALL give code 3 if mem_is_load and LOAD_LAT=1; if mem_is_load and LOAD_LAT=2 it SHALL be a stall condition; otherwise code 2.
REQ-006 An EXE match with exe_is_load SHALL be a load-use hazard; an EXE match without exe_is_load SHALL give code 1.
REQ-007 The id_rt source of a store SHALL NOT cause hazard or forwarding in ID; fwd_mem SHALL be 1 when mem_is_store, mem_rt≠0, wb_wen and wb_dst==mem_rt.
REQ-008 The FSM SHALL have states RUN=0, LSTALL=1, MWAIT=2, DHOLD=3.
REQ-009 In RUN, a load-use hazard SHALL load a counter with LOAD_LAT-1 and enter LSTALL, with the first bubble issued in the same cycle.
REQ-010 In RUN, id_mdu_read with mdu_busy (and no load-use hazard) SHALL enter MWAIT.
REQ-011 A bubble SHALL drive stage_en[if]=stage_en[id]=0 and stage_rst[exe]=1, while MEM and WB keep advancing.
REQ-012 LSTALL SHALL issue one bubble per cycle while the counter is nonzero, decrement it, and return to RUN when it reaches 0; total bubbles = LOAD_LAT.
REQ-013 MWAIT SHALL issue bubbles while mdu_busy=1 and return to RUN in the cycle mdu_busy=0, with no bubble in that cycle.
REQ-014 With DEBUG=1, debug_en=1 in any state SHALL enter DHOLD, with all stage_en=0 except in a cycle where debug_step rises (0→1 versus a registered copy), in which all stages advance once.
REQ-015 When debug_en falls in DHOLD, the FSM SHALL return to RUN, and LSTALL/MWAIT conditions SHALL be re-evaluated from the inputs.
REQ-016 With DEBUG=0, DHOLD SHALL be unreachable.
REQ-017 If DELAY_SLOT=0, id_branch_taken in RUN without a new stall SHALL assert stage_rst[id] for one cycle; id_branch_taken SHALL be ignored during any bubble.
REQ-018 Action priority SHALL be: rst > DHOLD > load-use > MWAIT > branch squash.
REQ-019 Forward selects SHALL be combinational from the current inputs in every state.

Reset
REQ-020 While rst=1: stage_rst=5'b11111, stage_en=5'b11111, fwd_a=fwd_b=0, fwd_mem=0, state=RUN, counter=0, registered debug_step=0.
REQ-021 rst asserted mid-LSTALL, MWAIT or DHOLD SHALL abort to RUN at the next edge with no residual bubble.

Structure
REQ-022 The shared package SHALL hold the fwd code constants, the state encoding and the stage index constants (IF=0 … WB=4).
REQ-023 One sub-module, hazard_fwd_sel (one instance per source operand, combinational match/priority), is natural; the FSM and counter SHALL stay in the top level.

Verification
REQ-024 A load in EXE with exe_dst=5, ID rs=5 used, LOAD_LAT=1 -> exactly 1 bubble, then fwd_a=3 for one cycle.
REQ-025 The same stimulus with LOAD_LAT=2 -> 2 consecutive bubbles, then fwd_a=4.
REQ-026 exe_dst=mem_dst=wb_dst=7 with all wen set and ALU ops, ID rt=7 -> fwd_b=1; with rt=0 -> fwd_b=0.
REQ-027 id_mdu_read with mdu_busy held high for 4 cycles -> 4 bubbles, RUN in cycle 5; with rst pulsed in cycle 2 -> RUN next cycle, with all stage_rst high for that cycle.
REQ-028 DEBUG=1, debug_en=1, debug_step toggled 0→1 twice -> exactly 2 cycles with stage_en=5'b11111, all others 0.
REQ-029 DELAY_SLOT=0 with id_branch_taken in RUN -> stage_rst[id]=1 for one cycle; id_branch_taken during LSTALL -> no squash.
